div_seq: RTL
============

# div_seq

Sequencer and HI/LO register stage wrapped around the iterative unsigned divider. It takes DIV/DIVU requests from the CPU control unit, converts signed operands to magnitudes, and loads the divider. It then waits the divider's fixed latency, applies sign correction to the quotient and remainder, and commits them to the architectural HI/LO registers. It also services MTHI/MTLO and holds `busy` high so the control unit stalls MFHI/MFLO until the result is committed.

## Interface
- `DIV_LAT`, default 33: divider cycles from the load pulse's falling edge to valid `div_lo`/`div_hi` (32 iterations plus the output register).
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low.
- `start` input, 1 bit: one-cycle request to divide `a` by `b`.
- `is_signed` input, 1 bit: 1 selects DIV, 0 selects DIVU; sampled with `start`.
- `a` input, 32 bits: dividend, sampled with `start`.
- `b` input, 32 bits: divisor, sampled with `start`.
- `mthi` input, 1 bit: write `wdata` to HI.
- `mtlo` input, 1 bit: write `wdata` to LO.
- `wdata` input, 32 bits: data for MTHI/MTLO.
- `hi` output, 32 bits: architectural HI (remainder).
- `lo` output, 32 bits: architectural LO (quotient).
- `busy` output, 1 bit: a divide is in flight; the control unit stalls MFHI/MFLO and a new `start`.
- `done` output, 1 bit: one-cycle pulse in the cycle HI/LO update from a divide.
- `div_load` output, 1 bit: active-high load pulse to the divider's active-high `reset` input.
- `div_a` output, 32 bits: dividend magnitude to the divider.
- `div_b` output, 32 bits: divisor magnitude to the divider.
- `div_lo` input, 32 bits: unsigned quotient from the divider.
- `div_hi` input, 32 bits: unsigned remainder from the divider.

## Operation
- States: IDLE, LOAD, RUN, FIX.
- IDLE: `busy`=0.
  - `start`=1 with `b`≠0: latch `a`, `b`, `is_signed`; record `neg_q` = signed & (a[31]^b[31]) and `neg_r` = signed & a[31]; go to LOAD.
  - `start`=1 with `b`=0: stay in IDLE. Next edge: LO←32'hFFFFFFFF, HI←`a`, `done`=1. The divider is not started.
- LOAD: `div_load`=1 for exactly one cycle; `div_a`/`div_b` = two's-complement magnitudes when signed (raw values when unsigned). Counter←0; go to RUN.
- RUN: `div_a`/`div_b` held stable. Counter increments each cycle; on counter = `DIV_LAT`-1, go to FIX.
- FIX: sample `div_lo`/`div_hi`.
  - LO ← `neg_q` ? −div_lo : div_lo.
  - HI ← `neg_r` ? −div_hi : div_hi.
  - `done`=1; go to IDLE.
- All arithmetic is 32-bit modulo. Negating 32'h80000000 yields 32'h80000000.
  - Signed 32'h80000000 / 32'hFFFFFFFF therefore gives LO=32'h80000000, HI=0. No trap.
- `start` while `busy`=1: ignored.
- MTHI/MTLO:
  - In IDLE: take effect at the next edge.
  - While `busy`=1: ignored; the divide result wins.
  - Same cycle as an IDLE divide-by-zero `start`: the divide-by-zero result wins.
- `mthi` and `mtlo` asserted together: both registers are written with `wdata`.

## Timing
- Reset (async assert): state IDLE; `hi`=`lo`=0; `busy`=`done`=`div_load`=0; `div_a`=`div_b`=0; counter 0.
- Reset release: operation resumes on the first rising edge.
- Reset mid-divide: abort immediately; HI/LO return to 0; no `done`.
- `busy` rises the edge after an accepted `start` and falls the edge FIX completes. `done` and the new HI/LO appear on that same edge.
- Latency from `start` edge to committed result: `DIV_LAT`+2 cycles (35 at default). Divide-by-zero: 1 cycle.
- A `start` asserted in the cycle `done`=1 is accepted, which allows back-to-back divides.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `uc_pkg`:
  - state enum `div_seq_state_t` {IDLE, LOAD, RUN, FIX}
  - constant `DIV0_LO` = 32'hFFFFFFFF
  - default `DIV_LAT` = 33
- No sub-module inside the block. The divider is instantiated alongside `div_seq` by the parent and wired through the `div_*` ports.

## Test plan
- DIVU 100/7 → after 35 cycles `done`, LO=14, HI=2, `busy` high throughout.
- DIV −100/7 (32'hFFFFFF9C, 7) → LO=32'hFFFFFFF2 (−14), HI=32'hFFFFFFFE (−2); DIV 100/−7 → LO=−14, HI=2.
- DIV 32'h80000000/32'hFFFFFFFF → LO=32'h80000000, HI=0; DIVU 5/0 → next cycle LO=32'hFFFFFFFF, HI=5, `div_load` never asserts.
- MTLO 32'hDEAD in IDLE → `lo`=32'hDEAD next edge. MTHI during RUN → ignored; HI = divide remainder. Second `start` during RUN → ignored, single `done`.
- Reset asserted at RUN cycle 10 → outputs 0 asynchronously. After release, DIVU 9/3 → LO=3, HI=0 in 35 cycles.
- Back-to-back: `start` (20/6) in the `done` cycle of 9/3 → second `done` 35 cycles later with LO=3, HI=2.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared definitions for the CPU multiply/divide control slice.
//
// Contents:
//   div_seq_state_t : sequencer states for the divide sequencer
//   DIV0_LO         : quotient committed to LO on a divide by zero
//   DIV_LAT_DEFAULT : default divider latency, load falling edge to valid result
//   mag32()         : 32-bit two's-complement magnitude, optionally signed
package uc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } div_seq_state_t;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  // 32 iterations plus the divider's output register.
  localparam int DIV_LAT_DEFAULT = 33;

  // Magnitude of v when sgn is set and v is negative; raw value otherwise.
  // Modulo-2^32, so the magnitude of 32'h80000000 is 32'h80000000.
  function automatic logic [31:0] mag32(input logic sgn, input logic [31:0] v);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/div_seq.sv
// Divide sequencer and architectural HI/LO register stage.
//
// Accepts DIV/DIVU requests, loads an external iterative unsigned divider
// with operand magnitudes, waits its fixed latency, sign-corrects the
// quotient/remainder and commits them to HI/LO. Also services MTHI/MTLO.
//
// Request handshake: start is a one-cycle request. It is accepted on a rising
// edge only while busy is low; busy rises on that same edge and stays high
// until the edge that commits the result (where done pulses for one cycle).
// A start presented while busy is high is dropped, never queued.
//
// Ports:
//   clk, reset      : clock (rising edge), asynchronous active-low reset
//   start           : one-cycle divide request
//   is_signed       : 1 = DIV, 0 = DIVU (sampled with start)
//   a, b            : dividend / divisor (sampled with start)
//   mthi, mtlo      : write wdata to HI / LO (honoured only while idle)
//   wdata           : MTHI/MTLO data
//   hi, lo          : architectural HI (remainder) / LO (quotient)
//   busy            : divide in flight
//   done            : one-cycle pulse on the edge HI/LO take a divide result
//   div_load        : load pulse to the divider (its active-high reset)
//   div_a, div_b    : operand magnitudes to the divider
//   div_lo, div_hi  : unsigned quotient / remainder from the divider
module div_seq
  import uc_pkg::*;
#(
  parameter int DIV_LAT = DIV_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_load,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_lo,
  input  logic [31:0] div_hi
);

  localparam int CW = $clog2(DIV_LAT) + 1;

  div_seq_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    hi_q, hi_d;
  logic [31:0]    lo_q, lo_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           div_load_q, div_load_d;
  logic [31:0]    div_a_q, div_a_d;
  logic [31:0]    div_b_q, div_b_d;
  logic           neg_q_q, neg_q_d;
  logic           neg_r_q, neg_r_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_load_d = 1'b0;
    div_a_d    = div_a_q;
    div_b_d    = div_b_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;

    case (state_q)
      IDLE: begin
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (start && (b != 32'd0)) begin
          // Operands go out as magnitudes; the signs are remembered so the
          // unsigned result can be corrected in FIX. The remainder takes the
          // dividend's sign, the quotient the XOR of both signs.
          div_a_d    = mag32(is_signed, a);
          div_b_d    = mag32(is_signed, b);
          neg_q_d    = is_signed & (a[31] ^ b[31]);
          neg_r_d    = is_signed & a[31];
          div_load_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = LOAD;
        end else if (start) begin
          // Divide by zero completes on this edge without the divider and
          // overrides any simultaneous MTHI/MTLO.
          lo_d   = DIV0_LO;
          hi_d   = a;
          done_d = 1'b1;
        end
      end

      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end

      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DIV_LAT - 1)) state_d = FIX;
      end

      FIX: begin
        lo_d    = neg_q_q ? (32'd0 - div_lo) : div_lo;
        hi_d    = neg_r_q ? (32'd0 - div_hi) : div_hi;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_load_q <= 1'b0;
      div_a_q    <= '0;
      div_b_q    <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_load_q <= div_load_d;
      div_a_q    <= div_a_d;
      div_b_q    <= div_b_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_load = div_load_q;
  assign div_a    = div_a_q;
  assign div_b    = div_b_q;

endmodule
